// File: rtl/m_dm_load_unit.sv
// m_dm_load_unit
// Load path of the M stage. Takes one load request (address, width,
// signedness, destination tag), issues a single word-aligned read to data
// memory, waits a bounded number of cycles for the read data, then returns
// the selected byte/halfword/word sign- or zero-extended to 32 bits.
//
// Optional feature: define ALIGN_CHECK_EN to flag misaligned halfword/word
// loads. Those loads skip memory and respond at once with rsp_err=1.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   req_valid/req_ready     request handshake
//   req_addr, req_type,     byte address, access width (W/H/B, code 3 = W),
//   req_sign, req_rd        sign-extend select, destination tag
//   mem_rd_en, mem_addr     one-cycle read strobe and aligned word address
//   mem_rdata, mem_rvalid   read data and its valid strobe
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_rd,       extended result, echoed tag,
//   rsp_err                 timeout (or misalignment) flag
module m_dm_load_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_type,
    input  logic        req_sign,
    input  logic [4:0]  req_rd,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    // Access width codes; code 2'b11 is reserved and handled as a word.
    localparam logic [1:0] TYPE_W = 2'b00;
    localparam logic [1:0] TYPE_H = 2'b01;
    localparam logic [1:0] TYPE_B = 2'b10;

    // Counter value seen in the last allowed WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [1:0]  type_q;
    logic        sign_q;
    logic [7:0]  cnt;
    logic        misalign;
    logic        wait_done;
    logic [31:0] byte_sh;
    logic [15:0] half_v;
    logic [31:0] ext_data;

`ifdef ALIGN_CHECK_EN
    assign misalign = ((req_type == TYPE_H) && req_addr[0]) ||
                      ((req_type != TYPE_H) && (req_type != TYPE_B) &&
                       (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !reset;
    assign mem_rd_en = (state == READ);
    assign mem_addr  = (state == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign rsp_valid = (state == RESP);

    // Late rvalid in the final WAIT cycle still wins over the timeout.
    assign wait_done = mem_rvalid || (cnt == CNT_LAST);

    // Lane select from the captured address offset.
    always_comb begin
        byte_sh  = mem_rdata >> {addr_q[1:0], 3'b000};
        half_v   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_data = mem_rdata;
        case (type_q)
            TYPE_B:  ext_data = {{24{sign_q & byte_sh[7]}}, byte_sh[7:0]};
            TYPE_H:  ext_data = {{16{sign_q & half_v[15]}}, half_v};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = misalign ? RESP : READ;
            READ: state_nxt = WAIT;
            WAIT: if (wait_done) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 32'h0;
            type_q   <= 2'b00;
            sign_q   <= 1'b0;
            cnt      <= 8'h0;
            rsp_data <= 32'h0;
            rsp_rd   <= 5'h0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    type_q   <= req_type;
                    sign_q   <= req_sign;
                    rsp_rd   <= req_rd;
                    rsp_data <= 32'h0;
                    rsp_err  <= misalign;
                end
                READ: cnt <= 8'h0;
                WAIT: begin
                    cnt <= cnt + 8'h1;
                    if (mem_rvalid) begin
                        rsp_data <= ext_data;
                        rsp_err  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data <= 32'h0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
